// File: rtl/ram_copy_engine.sv
// ram_copy_engine
//   Master for a dual-port RAM with a registered port-A read. Port A is used
//   only for reads, port B only for writes. Two transfer modes:
//     COPY (mode=0): block move src -> dst. Reads run one cycle ahead of the
//                    writes, so one word is moved per cycle.
//     FILL (mode=1): writes the constant fill_data to a block.
//   All addresses wrap modulo the RAM depth.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request pulse, accepted only in IDLE
//   mode                0 = COPY, 1 = FILL (latched with start)
//   src_addr, dst_addr  first source / destination address
//   len                 word count, 0..2**ADDR_W (larger values are rejected)
//   fill_data           FILL value (latched with start)
//   busy                transfer in progress
//   done                one-cycle pulse when a transfer completes
//   error               one-cycle pulse when a request is rejected
//   we_a, addr_a        port A write enable (always 0) and read address
//   dout_a              port A read data, valid one cycle after addr_a
//   we_b, addr_b, din_b port B write enable, address and data
module ram_copy_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] dout_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] din_b
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_reg, state_next;
    logic                mode_reg, mode_next;
    logic [DATA_W-1:0]   fill_reg, fill_next;
    logic [ADDR_W:0]     cnt_reg, cnt_next;      // writes still to issue, incl. current
    logic [ADDR_W-1:0]   addr_a_reg, addr_a_next;
    logic [ADDR_W-1:0]   addr_b_reg, addr_b_next;
    logic                we_b_reg, we_b_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                error_reg, error_next;

    // A COPY whose destination starts 1..len-1 words ahead of the source
    // would overwrite source words before they are read.
    logic [ADDR_W-1:0]   gap;
    logic                overlap;
    logic                too_long;

    assign gap      = dst_addr - src_addr;
    assign overlap  = (gap != '0) && ({1'b0, gap} < len);
    assign too_long = (len > LEN_MAX);

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        fill_next   = fill_reg;
        cnt_next    = cnt_reg;
        addr_a_next = addr_a_reg;
        addr_b_next = addr_b_reg;
        we_b_next   = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        error_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next = mode;
                    fill_next = fill_data;
                    if (too_long || (!mode && overlap)) begin
                        state_next = S_ERR;
                        error_next = 1'b1;
                    end else if (len == '0) begin
                        // Empty request: one quiet cycle in DONE, then the pulse.
                        state_next = S_DONE;
                    end else if (!mode) begin
                        // COPY: issue the first read now, first write next cycle.
                        state_next  = S_PRIME;
                        cnt_next    = len;
                        addr_a_next = src_addr;
                        addr_b_next = dst_addr;
                        busy_next   = 1'b1;
                    end else begin
                        state_next  = S_XFER;
                        cnt_next    = len;
                        addr_b_next = dst_addr;
                        we_b_next   = 1'b1;
                        busy_next   = 1'b1;
                    end
                end
            end

            S_PRIME: begin
                state_next  = S_XFER;
                addr_a_next = addr_a_reg + 1'b1;
                we_b_next   = 1'b1;
                busy_next   = 1'b1;
            end

            S_XFER: begin
                if (cnt_reg == LEN_ONE) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next    = cnt_reg - 1'b1;
                    addr_b_next = addr_b_reg + 1'b1;
                    if (!mode_reg) begin
                        addr_a_next = addr_a_reg + 1'b1;
                    end
                    we_b_next = 1'b1;
                    busy_next = 1'b1;
                end
            end

            S_DONE: begin
                if (done_reg) begin
                    state_next = S_IDLE;
                end else begin
                    done_next = 1'b1;
                end
            end

            S_ERR: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            mode_reg   <= 1'b0;
            fill_reg   <= '0;
            cnt_reg    <= '0;
            addr_a_reg <= '0;
            addr_b_reg <= '0;
            we_b_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            fill_reg   <= fill_next;
            cnt_reg    <= cnt_next;
            addr_a_reg <= addr_a_next;
            addr_b_reg <= addr_b_next;
            we_b_reg   <= we_b_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign error  = error_reg;
    assign we_a   = 1'b0;
    assign addr_a = addr_a_reg;
    assign we_b   = we_b_reg;
    assign addr_b = addr_b_reg;
    assign din_b  = mode_reg ? fill_reg : dout_a;

endmodule
